uart_fifo_ctl: RTL and testbench
================================

// Module: uart_fifo_ctl
// PURPOSE
//  Memory-mapped UART controller: TX and RX FIFOs between the bus and the UART TX/RX engines.
//  Bus writes push bytes into the TX FIFO; an internal FSM drains them to the TX engine, one byte at a time.
//  Received bytes are queued in the RX FIFO. Overrun, break and level status are exposed in registers.
//  Sits in the peripheral block and is selected by uart_request.
// PARAMETERS
//  TX_DEPTH      16  TX FIFO entries; power of 2, 2..128
//  RX_DEPTH      16  RX FIFO entries; power of 2, 2..128
//  RX_IRQ_LEVEL  1   RX level (>=) at which the rx_thresh condition is true; 1..RX_DEPTH
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  uart_request   in   1   block select
//  mem_addr       in   32  byte address; only [4:0] decoded
//  mem_wdata      in   32  write data
//  mem_we         in   1   write strobe (qualified by uart_request)
//  mem_re         in   1   read strobe (qualified by uart_request)
//  mem_rdata      out  32  read data, combinational; 0 when not (uart_request && mem_re)
//  uart_tx_en     out  1   one-cycle start pulse to TX engine
//  uart_tx_data   out  8   byte to send; stable from pulse until busy falls
//  uart_tx_busy   in   1   TX engine busy
//  uart_rx_en     out  1   RX engine enable (CTRL[1])
//  uart_rx_break  in   1   break detected (level)
//  uart_rx_valid  in   1   one-cycle received-byte strobe
//  uart_rx_data   in   8   received byte
//  irq            out  1   level interrupt (UART_IRQ_EN only; else 0)
// BEHAVIOUR
//  Reset: FIFOs empty, CTRL=0, sticky flags=0, FSM IDLE, uart_tx_en=0, uart_tx_data=0, uart_rx_en=0, irq=0.
//  Each cycle with uart_request && mem_we (wr) or uart_request && mem_re (rd) is one access.
//  0x00 TXDATA  wr: push wdata[7:0]. If full: drop the byte, set tx_ovf. rd: 0.
//  0x04 STATUS  rd: [0] tx_active (FSM!=IDLE | uart_tx_busy), [1] tx_full, [2] tx_empty,
//         [3] rx_full, [4] rx_empty, [5] tx_ovf, [6] rx_ovf, [7] rx_break,
//         [15:8] tx_count, [23:16] rx_count; other bits 0.
//         wr: write-1-to-clear [7:5]. All other bits ignored.
//  0x08 RXDATA  rd: returns {24'b0, head}; pops at the clock edge. When empty: returns 0, no pop. wr: ignored.
//  0x0C CTRL    rw: [0] tx_enable (drain), [1] rx_en. Bits [2] tx_flush and [3] rx_flush are
//         write-1 actions and always read 0.
//  0x10 IRQ     see CONFIGURATION. Other addresses: read 0, writes ignored.
//  Counts are $clog2(DEPTH)+1 bits, zero-extended. FIFO pointers wrap modulo DEPTH.
//  rx_break: set while uart_rx_break=1; sticky until W1C, with set winning over a same-cycle clear.
//  rx_ovf: set when uart_rx_valid arrives while RX is full (count taken before the edge); the byte is dropped.
//   This applies even if a pop happens in the same cycle.
//  RX push and pop in the same cycle, not full and not empty: both take effect and the count is unchanged.
//  RX bytes are pushed whenever uart_rx_valid=1, independent of rx_en.
//  TX push and FSM pop in the same cycle: both take effect.
//  Flush clears the FIFO at the edge. It wins over a same-cycle push or pop; the in-flight TX byte is not aborted.
//  TX FSM:
//   IDLE  -> LOAD when tx_enable & !empty & !uart_tx_busy.
//   LOAD: pop the head into uart_tx_data, assert uart_tx_en for exactly 1 cycle, -> WAIT_BUSY.
//   WAIT_BUSY -> WAIT_DONE when uart_tx_busy=1.
//   WAIT_DONE -> IDLE when uart_tx_busy=0.
//  Latency: TXDATA write at edge N with FSM IDLE and enabled -> uart_tx_en high in the cycle after edge N+1.
//  Clearing tx_enable mid-byte finishes the current byte, then holds in IDLE.
//  Reset asserted mid-operation: all state returns to reset values at the next edge.
// CONFIGURATION
//  UART_IRQ_EN defined:
//   0x10 rw [3:0] enables {break, ovf, tx_empty, rx_thresh}; reset 0.
//   0x10 rd [11:8] raw conditions {rx_break, tx_ovf|rx_ovf, tx_empty, rx_count>=RX_IRQ_LEVEL}.
//   irq = registered |(enable & cond), one cycle after the condition changes.
//  UART_IRQ_EN undefined: no 0x10 register (reads 0, writes ignored); irq tied to 0.
// TESTING
//  Reset, then read all registers -> STATUS=0x00000014, CTRL=0, irq=0, uart_tx_en=0.
//  CTRL=1; write 0x41,0x42,0x43; model busy for 10 cycles after each pulse
//   -> three pulses with data 0x41,0x42,0x43 in order; tx_empty=1 afterwards.
//  TX_DEPTH=16, CTRL=0: write 17 bytes -> tx_count=16, tx_full=1, tx_ovf=1; W1C 0x20 -> tx_ovf=0.
//  Inject 0x55,0xAA via uart_rx_valid; read 0x08 twice, then a third time
//   -> 0x55, 0xAA, 0; rx_empty=1; rx_count returns to 0.
//  RX full plus a same-cycle rx_valid and RXDATA read -> byte dropped, rx_ovf=1, rx_count=RX_DEPTH-1.
//  UART_IRQ_EN: IRQ=0x1, RX_IRQ_LEVEL=1, inject 1 byte -> irq=1; read RXDATA -> irq=0 next cycle.

Source files
------------

// File: rtl/uart_fifo_ctl.sv
// uart_fifo_ctl: memory-mapped UART controller with TX/RX byte FIFOs.
// Bus writes fill the TX FIFO, and a small FSM hands the bytes to the TX engine one at a time.
// Received bytes queue in the RX FIFO. Sticky overrun and break flags are write-1-to-clear.
// Optional feature: define UART_IRQ_EN to get the 0x10 IRQ enable/condition register and a live irq.
module uart_fifo_ctl #(
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int RX_IRQ_LEVEL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_request,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_busy,
    output logic        uart_rx_en,
    input  logic        uart_rx_break,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL_CNT = TX_DEPTH[TAW:0];
    localparam logic [RAW:0] RX_FULL_CNT = RX_DEPTH[RAW:0];

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state, state_nx;
    logic [1:0]     ctrl;
    logic           tx_ovf, rx_ovf, rx_brk;
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [TAW:0]   tx_cnt;
    logic [RAW:0]   rx_cnt;

    // Bus decode: only [4:0] of the address matters.
    logic       wr, rd;
    logic [4:0] addr;
    logic       tx_wr, stat_wr, ctrl_wr, rx_rd;
    assign wr      = uart_request & mem_we;
    assign rd      = uart_request & mem_re;
    assign addr    = mem_addr[4:0];
    assign tx_wr   = wr && (addr == 5'h00);
    assign stat_wr = wr && (addr == 5'h04);
    assign ctrl_wr = wr && (addr == 5'h0C);
    assign rx_rd   = rd && (addr == 5'h08);

    logic tx_full, tx_empty, rx_full, rx_empty;
    assign tx_full  = (tx_cnt == TX_FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == RX_FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    logic tx_flush, rx_flush, tx_push, tx_pop, rx_push, rx_pop, go_load;
    assign tx_flush = ctrl_wr & mem_wdata[2];
    assign rx_flush = ctrl_wr & mem_wdata[3];
    assign tx_push  = tx_wr & ~tx_full;
    // The head leaves the FIFO on the edge that enters LOAD, so the byte is already on uart_tx_data during the pulse.
    assign go_load  = (state == IDLE) & ctrl[0] & ~tx_empty & ~uart_tx_busy;
    assign tx_pop   = go_load;
    assign rx_push  = uart_rx_valid & ~rx_full;
    assign rx_pop   = rx_rd & ~rx_empty;

    // TX FIFO pointers and level; flush overrides any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_cnt <= tx_cnt + {{TAW{1'b0}}, tx_push} - {{TAW{1'b0}}, tx_pop};
        end
    end

    // RX FIFO pointers and level.
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_cnt <= rx_cnt + {{RAW{1'b0}}, rx_push} - {{RAW{1'b0}}, rx_pop};
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= mem_wdata[7:0];
        if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
    end

    // Byte presented to the TX engine, held until the next load.
    always_ff @(posedge clk) begin
        if (rst)          uart_tx_data <= 8'h00;
        else if (go_load) uart_tx_data <= tx_mem[tx_rp];
    end

    // TX FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // TX FSM next state: wait for busy to rise and then fall before the next byte.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (go_load) state_nx = LOAD;
            LOAD:      state_nx = WAIT_BUSY;
            WAIT_BUSY: if (uart_tx_busy) state_nx = WAIT_DONE;
            WAIT_DONE: if (!uart_tx_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // TX FSM outputs: the start pulse is exactly the LOAD cycle.
    always_comb begin
        uart_tx_en = (state == LOAD);
    end

    // Control register and sticky flags; a flag being set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl   <= 2'b00;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
            rx_brk <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= mem_wdata[1:0];
            if (stat_wr && mem_wdata[5]) tx_ovf <= 1'b0;
            if (stat_wr && mem_wdata[6]) rx_ovf <= 1'b0;
            if (stat_wr && mem_wdata[7]) rx_brk <= 1'b0;
            if (tx_wr && tx_full)        tx_ovf <= 1'b1;
            if (uart_rx_valid && rx_full) rx_ovf <= 1'b1;
            if (uart_rx_break)           rx_brk <= 1'b1;
        end
    end

    assign uart_rx_en = ctrl[1];

    logic [31:0] irq_rd;
`ifdef UART_IRQ_EN
    logic [3:0] irq_en, irq_cond;
    logic       irq_q, irq_wr;
    assign irq_wr   = wr && (addr == 5'h10);
    assign irq_cond = {rx_brk, tx_ovf | rx_ovf, tx_empty, rx_cnt >= RX_IRQ_LEVEL[RAW:0]};

    // IRQ enables and the registered interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 4'h0;
            irq_q  <= 1'b0;
        end else begin
            if (irq_wr) irq_en <= mem_wdata[3:0];
            irq_q <= |(irq_en & irq_cond);
        end
    end

    assign irq    = irq_q;
    assign irq_rd = {20'h0, irq_cond, 4'h0, irq_en};
`else
    assign irq    = 1'b0;
    assign irq_rd = 32'h0;
`endif

    logic [31:0] status;
    assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt), rx_brk, rx_ovf, tx_ovf,
                     rx_empty, rx_full, tx_empty, tx_full, (state != IDLE) | uart_tx_busy};

    // Combinational read mux; zero unless this block is selected for a read.
    always_comb begin
        mem_rdata = 32'h0;
        if (rd) begin
            case (addr)
                5'h04:   mem_rdata = status;
                5'h08:   mem_rdata = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rp]};
                5'h0C:   mem_rdata = {30'h0, ctrl};
                5'h10:   mem_rdata = irq_rd;
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr[31:5], mem_wdata[31:8]};
endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Directed bench for uart_fifo_ctl: a vector table for register access and RX queueing,
// plus hand-written sequences for TX draining, overflow, flush, break, reset and IRQ.
module tb_uart_fifo_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_request = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_rdata;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy = 1'b0;
    logic        uart_rx_en;
    logic        uart_rx_break = 1'b0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        irq;

    uart_fifo_ctl #(.TX_DEPTH(16), .RX_DEPTH(16), .RX_IRQ_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .uart_request(uart_request), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
        .uart_rx_en(uart_rx_en), .uart_rx_break(uart_rx_break), .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data), .irq(irq)
    );

    always #5 clk = ~clk;

`ifdef UART_IRQ_EN
    localparam logic [31:0] EXP_IRQ_RST = 32'h0000_0200;
`else
    localparam logic [31:0] EXP_IRQ_RST = 32'h0000_0000;
`endif

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // TX engine model: busy rises the cycle after the start pulse and stays up for 10 cycles.
    always @(negedge clk) begin
        if (uart_tx_en) begin
            @(posedge clk);
            #1 uart_tx_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 uart_tx_busy = 1'b0;
        end
    end

    logic [7:0] tx_seen [$];
    always @(negedge clk) begin
        if (uart_tx_en) tx_seen.push_back(uart_tx_data);
    end

    // All tasks start and end 1 time unit after a rising edge, with the bus idle.
    task automatic bus(input logic we, input logic re, input logic [4:0] a,
                       input logic [31:0] d, output logic [31:0] r);
        uart_request = we | re;
        mem_we = we;
        mem_re = re;
        mem_addr = {27'h0, a};
        mem_wdata = d;
        @(negedge clk);
        r = mem_rdata;
        @(posedge clk);
        #1;
        uart_request = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, 1'b0, a, d, r);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, 1'b1, a, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic inject(input logic [7:0] d);
        uart_rx_valid = 1'b1;
        uart_rx_data = d;
        @(posedge clk);
        #1 uart_rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        we;
        logic        re;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vec [NVEC];

    initial begin
        logic [31:0] r;

        vec[0]  = '{1'b0, 1'b1, 5'h04, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0014};
        vec[1]  = '{1'b0, 1'b1, 5'h0C, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0000};
        vec[2]  = '{1'b0, 1'b1, 5'h00, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0000};
        vec[3]  = '{1'b0, 1'b1, 5'h08, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0000};
        vec[4]  = '{1'b0, 1'b1, 5'h10, 32'h0, 1'b0, 8'h00, 1'b1, EXP_IRQ_RST};
        vec[5]  = '{1'b0, 1'b1, 5'h14, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0000};
        vec[6]  = '{1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 8'h55, 1'b0, 32'h0000_0000};
        vec[7]  = '{1'b0, 1'b0, 5'h00, 32'h0, 1'b1, 8'hAA, 1'b0, 32'h0000_0000};
        vec[8]  = '{1'b0, 1'b1, 5'h04, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0002_0004};
        vec[9]  = '{1'b0, 1'b1, 5'h08, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0055};
        vec[10] = '{1'b0, 1'b1, 5'h08, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_00AA};
        vec[11] = '{1'b0, 1'b1, 5'h08, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0000};
        vec[12] = '{1'b0, 1'b1, 5'h04, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0000_0014};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tx_en", uart_tx_en, 0);
        check("rst_tx_data", uart_tx_data, 0);
        check("rst_rx_en", uart_rx_en, 0);
        check("rst_irq", irq, 0);

        for (int i = 0; i < NVEC; i++) begin
            uart_request = vec[i].we | vec[i].re;
            mem_we = vec[i].we;
            mem_re = vec[i].re;
            mem_addr = {27'h0, vec[i].addr};
            mem_wdata = vec[i].wdata;
            uart_rx_valid = vec[i].rxv;
            uart_rx_data = vec[i].rxd;
            @(negedge clk);
            if (vec[i].chk) check($sformatf("vec%0d", i), mem_rdata, vec[i].exp);
            @(posedge clk);
            #1;
            uart_request = 1'b0;
            mem_we = 1'b0;
            mem_re = 1'b0;
            uart_rx_valid = 1'b0;
        end

        // TX drain: latency, pulse width, order.
        wr(5'h0C, 32'h1);
        wr(5'h00, 32'h41);
        @(negedge clk);
        check("tx_lat_early", uart_tx_en, 0);
        @(negedge clk);
        check("tx_lat_pulse", uart_tx_en, 1);
        check("tx_data_at_pulse", uart_tx_data, 8'h41);
        @(negedge clk);
        check("tx_pulse_width", uart_tx_en, 0);
        @(posedge clk);
        #1;
        wr(5'h00, 32'h42);
        wr(5'h00, 32'h43);
        begin
            int t = 0;
            while (tx_seen.size() < 3 && t < 200) begin
                @(posedge clk);
                t++;
            end
            #1;
        end
        check("tx_pulse_count", tx_seen.size(), 3);
        for (int i = 0; i < 3 && i < tx_seen.size(); i++)
            check($sformatf("tx_order%0d", i), tx_seen[i], 8'h41 + i);
        idle(15);
        rd_chk("status_drained", 5'h04, 32'h0000_0014);

        // TX overflow with the drain disabled, then W1C and flush.
        wr(5'h0C, 32'h0);
        for (int i = 0; i < 17; i++) wr(5'h00, i);
        rd_chk("tx_full_ovf", 5'h04, 32'h0000_1032);
        wr(5'h04, 32'h20);
        rd_chk("tx_ovf_w1c", 5'h04, 32'h0000_1012);
        wr(5'h0C, 32'h4);
        rd_chk("tx_flush", 5'h04, 32'h0000_0014);
        rd_chk("ctrl_after_flush", 5'h0C, 32'h0);
        check("no_tx_when_disabled", tx_seen.size(), 3);

        // RX full with a same-cycle byte and pop: the byte is dropped.
        for (int i = 0; i < 16; i++) inject(8'(i + 1));
        rd_chk("rx_full", 5'h04, 32'h0010_000C);
        uart_rx_valid = 1'b1;
        uart_rx_data = 8'hEE;
        bus(1'b0, 1'b1, 5'h08, 32'h0, r);
        uart_rx_valid = 1'b0;
        check("rx_pop_while_full", r, 32'h01);
        rd_chk("rx_ovf", 5'h04, 32'h000F_0044);
        rd_chk("rx_head2", 5'h08, 32'h02);
        wr(5'h04, 32'h40);
        rd_chk("rx_ovf_w1c", 5'h04, 32'h000E_0004);
        wr(5'h0C, 32'h8);
        rd_chk("rx_flush", 5'h04, 32'h0000_0014);

        // Break: set wins over a same-cycle clear, then a clean clear.
        uart_rx_break = 1'b1;
        wr(5'h04, 32'h80);
        uart_rx_break = 1'b0;
        rd_chk("brk_set_wins", 5'h04, 32'h0000_0094);
        wr(5'h04, 32'h80);
        rd_chk("brk_cleared", 5'h04, 32'h0000_0014);

        // rx_en control bit.
        wr(5'h0C, 32'h2);
        check("rx_en_pin", uart_rx_en, 1);
        rd_chk("ctrl_rx_en", 5'h0C, 32'h2);

        // Reset in the middle of activity.
        wr(5'h00, 32'h77);
        inject(8'h99);
        uart_rx_break = 1'b1;
        idle(1);
        uart_rx_break = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rd_chk("status_after_rst", 5'h04, 32'h0000_0014);
        rd_chk("ctrl_after_rst", 5'h0C, 32'h0);
        check("rx_en_after_rst", uart_rx_en, 0);

`ifdef UART_IRQ_EN
        wr(5'h10, 32'h1);
        rd_chk("irq_reg", 5'h10, 32'h0000_0201);
        inject(8'h5A);
        idle(1);
        check("irq_on_rx", irq, 1);
        rd_chk("irq_rx_byte", 5'h08, 32'h5A);
        idle(1);
        check("irq_after_pop", irq, 0);
`else
        inject(8'h5A);
        idle(2);
        check("irq_tied_low", irq, 0);
        rd_chk("irq_reg_absent", 5'h10, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
